// File: rtl/dec_n_pipe_pkg.sv
// Shared types for the decoder pipeline: decode mode encoding and the
// output-width derivation used wherever an index is widened to a vector.
package dec_pkg;

  typedef enum logic [1:0] {
    ONEHOT   = 2'd0,
    THERM_LE = 2'd1,
    THERM_GT = 2'd2,
    ZERO     = 2'd3
  } mode_e;

  function automatic int out_w_f(input int in_w);
    return 32'sd1 << in_w;
  endfunction

endpackage

// File: rtl/dec_n_pipe_if.sv
// Request/response bundle of the decoder pipeline; master drives requests
// and consumes vectors, slave is the pipeline itself.
interface dec_n_pipe_if import dec_pkg::*; #(
  parameter int IN_W  = 5,
  parameter int DEPTH = 2
);
  localparam int OUT_W = out_w_f(IN_W);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_idx;
  mode_e            in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_vec;
  logic [CNT_W-1:0] out_cnt;

  modport master (
    output in_valid, in_idx, in_mode, out_ready,
    input  in_ready, out_valid, out_vec, out_cnt
  );

  modport slave (
    input  in_valid, in_idx, in_mode, out_ready,
    output in_ready, out_valid, out_vec, out_cnt
  );
endinterface

// File: rtl/dec_n_pipe_dec.sv
// Combinational index-to-vector decoder (one-hot, thermometer <=, thermometer >,
// or all-zero); kept standalone so other blocks can reuse it.
module dec_n import dec_pkg::*; #(
  parameter  int IN_W  = 5,
  localparam int OUT_W = out_w_f(IN_W)
) (
  input  logic [IN_W-1:0]  idx,
  input  mode_e            mode,
  output logic [OUT_W-1:0] vec
);

  // Per-bit decode against the index value.
  always_comb begin
    vec = '0;
    for (int i = 0; i < OUT_W; i++) begin
      case (mode)
        ONEHOT:   vec[i] = (i == int'(idx));
        THERM_LE: vec[i] = (i <= int'(idx));
        THERM_GT: vec[i] = (i > int'(idx));
        ZERO:     vec[i] = 1'b0;
        default:  vec[i] = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/dec_n_pipe.sv
// Decoder followed by a DEPTH-entry in-order FIFO of decoded vectors with
// ready/valid on both sides and pass-through acceptance when full.
module dec_n_pipe import dec_pkg::*; #(
  parameter int IN_W  = 5,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_aN,
  dec_n_pipe_if.slave  bus
);

  localparam int OUT_W = out_w_f(IN_W);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q;
  logic [OUT_W-1:0] dec_vec_s;
  logic             in_ready_s, out_valid_s, push_s, pop_s;

  // Pointers wrap at DEPTH-1 so non power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  dec_n #(.IN_W(IN_W)) u_dec (
    .idx  (bus.in_idx),
    .mode (bus.in_mode),
    .vec  (dec_vec_s)
  );

  // Handshake evaluation and next-state of pointers and occupancy.
  always_comb begin
    in_ready_s  = run_q && ((cnt_q < CNT_W'(DEPTH)) || bus.out_ready);
    out_valid_s = (cnt_q != '0);
    push_s      = bus.in_valid && in_ready_s;
    pop_s       = out_valid_s && bus.out_ready;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    if (push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; run_q holds in_ready low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_aN) begin
    if (!rst_aN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      run_q    <= 1'b1;
    end
  end

  // Data storage is unreset; the empty mask on out_vec hides stale contents.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= dec_vec_s;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_vec   = out_valid_s ? mem_q[rd_ptr_q] : '0;
  assign bus.out_cnt   = cnt_q;

endmodule

// File: doc/dec_n_pipe.md
DEC_N_PIPE -- requirements
Module: dec_n_pipe

Interface
REQ-001 Parameter IN_W, default 5, index width; SHALL satisfy 1 <= IN_W <= 6.
REQ-002 Derived constant OUT_W = 2**IN_W (default 32), output vector width; not overridable.
REQ-003 Parameter DEPTH, default 2, output buffer entries; SHALL satisfy DEPTH >= 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_aN  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream request present.
REQ-007 in_ready  output  1  block accepts a request this cycle.
REQ-008 in_idx  input  IN_W  index to decode.
REQ-009 in_mode  input  2  decode mode: ONEHOT=0, THERM_LE=1, THERM_GT=2, ZERO=3.
REQ-010 out_valid  output  1  decoded vector present.
REQ-011 out_ready  input  1  downstream accepts the vector this cycle.
REQ-012 out_vec  output  OUT_W  decoded vector.
REQ-013 out_cnt  output  $clog2(DEPTH+1)  number of occupied buffer entries.

Function
REQ-014 Decode rules: ONEHOT sets bit i iff i == idx; THERM_LE sets bit i iff i <= idx; THERM_GT sets bit i iff i > idx; ZERO clears all bits.
REQ-015 A request SHALL transfer when in_valid && in_ready at a rising edge; the decoded vector SHALL be computed from in_idx/in_mode at that edge and stored.
REQ-016 An output SHALL transfer when out_valid && out_ready at a rising edge.
REQ-017 The buffer SHALL be an in-order FIFO of DEPTH entries holding decoded OUT_W vectors.
REQ-018 in_ready SHALL be 1 iff out_cnt < DEPTH, or out_cnt == DEPTH && out_ready (pass-through on full); no combinational path from in_valid to in_ready.
REQ-019 out_valid SHALL be 1 iff out_cnt > 0; out_vec SHALL show the oldest entry; no combinational path from in_* to out_*.
REQ-020 Latency: a request accepted at edge N into an empty buffer SHALL appear on out_vec with out_valid=1 from edge N until its transfer.
REQ-021 out_vec and out_valid SHALL stay stable while out_valid && !out_ready.
REQ-022 Simultaneous push and pop SHALL leave out_cnt unchanged, including at out_cnt == DEPTH and at out_cnt == 1.
REQ-023 Pop with no push SHALL decrement out_cnt; push with no pop SHALL increment out_cnt; out_cnt SHALL never exceed DEPTH nor underflow.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH, DEPTH not required to be a power of two.
REQ-025 When out_cnt == 0, out_vec SHALL be all-zero.
REQ-026 in_idx and in_mode SHALL be ignored when in_valid == 0 or in_ready == 0.

Reset
REQ-027 While rst_aN == 0: out_cnt=0, out_valid=0, out_vec=0, in_ready=0, pointers=0, regardless of clk.
REQ-028 in_ready SHALL become 1 at the first rising edge after rst_aN deasserts; reset asserted mid-transfer SHALL discard all buffered entries.
REQ-029 Buffer data storage need not be reset, but SHALL not be visible on out_vec while out_cnt == 0.

Structure
REQ-030 Shared package dec_pkg SHALL hold the 2-bit mode enum (ONEHOT, THERM_LE, THERM_GT, ZERO) and the OUT_W derivation function.
REQ-031 Combinational decode SHALL be a sub-module dec_n (parameter IN_W; inputs idx, mode; output vec), reusable elsewhere in the core.
REQ-032 dec_n_pipe SHALL instantiate one dec_n and the FIFO control; no other hierarchy.

Verification
REQ-033 Reset then idx=5, mode=ONEHOT, out_ready=1 -> next cycle out_vec=32'h0000_0020, out_valid=1, out_cnt=1.
REQ-034 idx=3 THERM_LE, then idx=3 THERM_GT, out_ready=1 -> out_vec 32'h0000_000F then 32'hFFFF_FFF0, in order.
REQ-035 Boundaries: idx=31 THERM_LE -> 32'hFFFF_FFFF; idx=31 THERM_GT -> 0; idx=0 ONEHOT -> 32'h1; any idx ZERO -> 0.
REQ-036 out_ready=0, push 3 requests (DEPTH=2) -> two accepted, in_ready=0 and out_cnt=2; out_vec stable; then out_ready=1 with in_valid=1 -> in_ready=1, out_cnt stays 2, FIFO order preserved.
REQ-037 rst_aN pulsed low mid-cycle with out_cnt=2 -> out_valid=0, out_cnt=0 immediately, without waiting for clk.
REQ-038 Random push/pop, IN_W=3 and IN_W=6, DEPTH=3 -> scoreboard match on every popped vector; no overflow/underflow.
